// File: rtl/serdes_word_align_pkg.sv
// rtl/serdes_word_align_pkg.sv - shared state encoding and counter widths for word alignment
package serdes_word_align_pkg;

    localparam int SLIP_CNT_W   = 4;
    localparam int MATCH_CNT_W  = 8;
    localparam int LOSS_CNT_W   = 8;
    localparam int SETTLE_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SLIP,
        ST_SETTLE,
        ST_LOCKED,
        ST_FAIL
    } state_t;

endpackage

// File: rtl/serdes_word_align_if.sv
// rtl/serdes_word_align_if.sv - word stream and alignment status bundle between I_SERDES side and aligner
interface serdes_word_align_if
    import serdes_word_align_pkg::*;
#(
    parameter int WIDTH = 4
);
    logic                  ALIGN_START;
    logic [WIDTH-1:0]      Q_IN;
    logic                  DATA_VALID_IN;
    logic                  BITSLIP_ADJ;
    logic                  ALIGNED;
    logic                  ALIGN_ERROR;
    logic [SLIP_CNT_W-1:0] SLIP_COUNT;
    logic [WIDTH-1:0]      Q_OUT;
    logic                  DATA_VALID_OUT;

    modport master (
        output ALIGN_START, Q_IN, DATA_VALID_IN,
        input  BITSLIP_ADJ, ALIGNED, ALIGN_ERROR, SLIP_COUNT, Q_OUT, DATA_VALID_OUT
    );

    modport slave (
        input  ALIGN_START, Q_IN, DATA_VALID_IN,
        output BITSLIP_ADJ, ALIGNED, ALIGN_ERROR, SLIP_COUNT, Q_OUT, DATA_VALID_OUT
    );
endinterface

// File: rtl/serdes_word_align.sv
// rtl/serdes_word_align.sv - bitslip-driven word boundary aligner for an I_SERDES word stream
module serdes_word_align
    import serdes_word_align_pkg::*;
#(
    parameter int         WIDTH         = 4,
    parameter logic [9:0] TRAIN_PATTERN = 10'h3C1,
    parameter int         MATCH_COUNT   = 8,
    parameter int         SETTLE_WORDS  = 4,
    parameter int         LOSS_COUNT    = 4
) (
    input logic               CLK_IN,
    input logic               RST,
    serdes_word_align_if.slave bus
);

    if (WIDTH < 3 || WIDTH > 10) begin : g_bad_width
        $error("serdes_word_align: WIDTH must be 3..10");
    end
    if (MATCH_COUNT < 1 || MATCH_COUNT > 255) begin : g_bad_match
        $error("serdes_word_align: MATCH_COUNT must be 1..255");
    end
    if (SETTLE_WORDS < 0 || SETTLE_WORDS > 15) begin : g_bad_settle
        $error("serdes_word_align: SETTLE_WORDS must be 0..15");
    end
    if (LOSS_COUNT < 1 || LOSS_COUNT > 255) begin : g_bad_loss
        $error("serdes_word_align: LOSS_COUNT must be 1..255");
    end

    localparam logic [WIDTH-1:0]        PATTERN    = TRAIN_PATTERN[WIDTH-1:0];
    localparam logic [SLIP_CNT_W-1:0]   SLIP_LIM   = SLIP_CNT_W'(WIDTH);
    localparam logic [MATCH_CNT_W-1:0]  MATCH_LIM  = MATCH_CNT_W'(MATCH_COUNT);
    localparam logic [LOSS_CNT_W-1:0]   LOSS_LIM   = LOSS_CNT_W'(LOSS_COUNT);
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LIM = SETTLE_CNT_W'(SETTLE_WORDS);

    state_t                  state_q, state_d;
    logic [MATCH_CNT_W-1:0]  match_q, match_d;
    logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
    logic [SETTLE_CNT_W-1:0] settle_q, settle_d;
    logic [SLIP_CNT_W-1:0]   slip_q, slip_d;
    logic [WIDTH-1:0]        q_out_q;
    logic                    dv_out_q;
    logic                    word_ok;

    assign word_ok = (bus.Q_IN == PATTERN);

    // State and counter registers; reset drops straight to IDLE so a slip pulse is cut short
    always_ff @(posedge CLK_IN or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IDLE;
            match_q  <= '0;
            loss_q   <= '0;
            settle_q <= '0;
            slip_q   <= '0;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            loss_q   <= loss_d;
            settle_q <= settle_d;
            slip_q   <= slip_d;
        end
    end

    // Next-state and counter updates; a word seen with an accepted ALIGN_START is not evaluated
    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        loss_d   = loss_q;
        settle_d = settle_q;
        slip_d   = slip_q;
        case (state_q)
            ST_IDLE, ST_FAIL: begin
                if (bus.ALIGN_START) begin
                    state_d  = ST_CHECK;
                    match_d  = '0;
                    loss_d   = '0;
                    settle_d = '0;
                    slip_d   = '0;
                end
            end
            ST_CHECK: begin
                if (bus.DATA_VALID_IN) begin
                    if (word_ok) begin
                        if (match_q != '1) match_d = match_q + 1'b1;
                        if (match_q >= MATCH_LIM - 1'b1) begin
                            state_d = ST_LOCKED;
                            loss_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                        state_d = (slip_q < SLIP_LIM) ? ST_SLIP : ST_FAIL;
                    end
                end
            end
            ST_SLIP: begin
                if (slip_q < SLIP_LIM) slip_d = slip_q + 1'b1;
                settle_d = '0;
                state_d  = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (SETTLE_WORDS == 0) begin
                    state_d = ST_CHECK;
                end else if (bus.DATA_VALID_IN) begin
                    if (settle_q >= SETTLE_LIM - 1'b1) begin
                        settle_d = '0;
                        state_d  = ST_CHECK;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (bus.ALIGN_START) begin
                    state_d  = ST_CHECK;
                    match_d  = '0;
                    loss_d   = '0;
                    settle_d = '0;
                    slip_d   = '0;
                end else if (bus.DATA_VALID_IN) begin
                    if (word_ok) begin
                        loss_d = '0;
                    end else if (loss_q >= LOSS_LIM - 1'b1) begin
                        state_d  = ST_CHECK;
                        match_d  = '0;
                        loss_d   = '0;
                        settle_d = '0;
                        slip_d   = '0;
                    end else begin
                        loss_d = loss_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Data path: Q passes through unconditionally, valid only while locked
    always_ff @(posedge CLK_IN or negedge RST) begin
        if (!RST) begin
            q_out_q  <= '0;
            dv_out_q <= 1'b0;
        end else begin
            q_out_q  <= bus.Q_IN;
            dv_out_q <= bus.DATA_VALID_IN && (state_q == ST_LOCKED);
        end
    end

    assign bus.BITSLIP_ADJ    = (state_q == ST_SLIP);
    assign bus.ALIGNED        = (state_q == ST_LOCKED);
    assign bus.ALIGN_ERROR    = (state_q == ST_FAIL);
    assign bus.SLIP_COUNT     = slip_q;
    assign bus.Q_OUT          = q_out_q;
    assign bus.DATA_VALID_OUT = dv_out_q;

endmodule
